// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer: NUM_CH prescaled down-counters with compare/PWM outputs
// and snapshot registers behind one registered-read Avalon-MM slave.

module nios_multi_timer_ch #(
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        cmp
);
    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] cnt, period, compare, snap;
    logic [PRE_W-1:0] prescale, pre_cnt;
    logic             to, run, ito, cont, cmp_en;

    logic wr_status, wr_ctrl, wr_period, wr_snap, wr_pre, wr_cmp;
    logic start, stop, tick, expire;

    assign wr_status = wr && (sel == 3'd0);
    assign wr_ctrl   = wr && (sel == 3'd1);
    assign wr_period = wr && (sel == 3'd2);
    assign wr_snap   = wr && (sel == 3'd3);
    assign wr_pre    = wr && (sel == 3'd4);
    assign wr_cmp    = wr && (sel == 3'd5);
    assign start     = wr_ctrl && wdata[2];
    assign stop      = wr_ctrl && wdata[3];
    assign tick      = run && (pre_cnt == prescale);
    assign expire    = tick && (cnt == '0);
    assign irq       = to && ito;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= RST_P;
            period   <= RST_P;
            compare  <= '0;
            snap     <= '0;
            prescale <= '0;
            pre_cnt  <= '0;
            to       <= 1'b0;
            run      <= 1'b0;
            ito      <= 1'b0;
            cont     <= 1'b0;
            cmp_en   <= 1'b0;
            cmp      <= 1'b0;
        end else begin
            if (wr_period) begin
                period <= wdata[CNT_W-1:0];
                cnt    <= wdata[CNT_W-1:0];
            end else if (tick) begin
                cnt <= expire ? period : cnt - CNT_W'(1);
            end
            // START beats STOP and a one-shot expiry in the same cycle
            if (wr_period)                     run <= 1'b0;
            else if (start)                    run <= 1'b1;
            else if (stop || (expire && !cont)) run <= 1'b0;
            // an expiry beats a concurrent clear so no event is lost
            if (expire)         to <= 1'b1;
            else if (wr_status) to <= 1'b0;
            if (wr_ctrl) begin
                ito    <= wdata[0];
                cont   <= wdata[1];
                cmp_en <= wdata[4];
            end
            if (wr_snap) snap     <= cnt;
            if (wr_pre)  prescale <= wdata[PRE_W-1:0];
            if (wr_cmp)  compare  <= wdata[CNT_W-1:0];
            if (start || wr_period || wr_pre) pre_cnt <= '0;
            else if (run)                     pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            cmp <= run && cmp_en && (cnt < compare);
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            3'd0:    rdata = {30'd0, run, to};
            3'd1:    rdata = {27'd0, cmp_en, 2'b00, cont, ito};
            3'd2:    rdata = 32'(period);
            3'd3:    rdata = 32'(snap);
            3'd4:    rdata = 32'(prescale);
            3'd5:    rdata = 32'(compare);
            default: rdata = '0;
        endcase
    end
endmodule

module nios_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_W+2:0]   address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_ch,
    output logic [NUM_CH-1:0] cmp_out
);
    logic [CH_W-1:0]             ch;
    logic [2:0]                  sel;
    logic [NUM_CH-1:0][31:0]     ch_rdata;
    logic [31:0]                 rd_mux;
    logic                        unused_read_n;

    assign ch            = address[CH_W+2:3];
    assign sel           = address[2:0];
    assign unused_read_n = read_n;
    assign irq           = |irq_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nios_multi_timer_ch #(
            .CNT_W(CNT_W), .PRE_W(PRE_W), .RESET_PERIOD(RESET_PERIOD)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .wr    (chipselect && !write_n && (ch == CH_W'(i))),
            .sel   (sel),
            .wdata (writedata),
            .rdata (ch_rdata[i]),
            .irq   (irq_ch[i]),
            .cmp   (cmp_out[i])
        );
    end

    // channel indices past NUM_CH fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch == CH_W'(i)) rd_mux = ch_rdata[i];
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end
endmodule

// File: tb/tb_nios_multi_timer.sv
// Bench for nios_multi_timer: register table, directed timing sequences, and a random
// bus run checked cycle-by-cycle against a behavioural model.

module tb_nios_multi_timer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b, cs_a, cs_b, write_n, read_n;
    logic [4:0]  address;
    logic [31:0] writedata, rd_a, rd_b;
    logic        irq_a, irq_b;
    logic [3:0]  irqch_a, cmp_a;
    logic [2:0]  irqch_b, cmp_b;
    int errors = 0, checks = 0;

    nios_multi_timer dut_a (
        .clk(clk), .reset(reset_a), .address(address), .chipselect(cs_a),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_a),
        .irq(irq_a), .irq_ch(irqch_a), .cmp_out(cmp_a));

    nios_multi_timer #(.NUM_CH(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset_b), .address(address), .chipselect(cs_b),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_b),
        .irq(irq_b), .irq_ch(irqch_b), .cmp_out(cmp_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // one bus cycle: entered and left at a falling edge
    task automatic op(input bit b, input bit w, input int c, input int r, input logic [31:0] d);
        address = 5'(c * 8 + r); writedata = d; write_n = !w; read_n = w;
        cs_a = !b; cs_b = b;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1; read_n = 1'b1;
    endtask

    task automatic wr(input bit b, input int c, input int r, input logic [31:0] d);
        op(b, 1'b1, c, r, d);
    endtask

    task automatic rd(input bit b, input int c, input int r, output logic [31:0] v);
        op(b, 1'b0, c, r, 32'd0);
        v = b ? rd_b : rd_a;
    endtask

    // ---------------- behavioural model of dut_a ----------------
    logic [31:0] m_cnt[4], m_per[4], m_cmp[4], m_snap[4], m_rd;
    int          m_pre[4], m_pc[4];
    bit          m_to[4], m_run[4], m_ito[4], m_cont[4], m_cen[4], m_cmpo[4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 49999; m_per[i] = 49999; m_cmp[i] = 0; m_snap[i] = 0;
            m_pre[i] = 0; m_pc[i] = 0; m_to[i] = 0; m_run[i] = 0;
            m_ito[i] = 0; m_cont[i] = 0; m_cen[i] = 0; m_cmpo[i] = 0;
        end
        m_rd = 0;
    endtask

    function automatic logic [31:0] model_read(input int c, input int r);
        case (r)
            0: return {30'd0, m_run[c], m_to[c]};
            1: return {27'd0, m_cen[c], 2'b00, m_cont[c], m_ito[c]};
            2: return m_per[c];
            3: return m_snap[c];
            4: return 32'(m_pre[c]);
            5: return m_cmp[c];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit cs, input bit wn, input logic [4:0] a, input logic [31:0] d);
        int c, r;
        bit w, tick, expire, start, stop;
        c = int'(a[4:3]); r = int'(a[2:0]);
        m_rd = model_read(c, r);
        for (int i = 0; i < 4; i++) begin
            w      = cs && !wn && (c == i);
            tick   = m_run[i] && (m_pc[i] == m_pre[i]);
            expire = tick && (m_cnt[i] == 0);
            start  = w && (r == 1) && d[2];
            stop   = w && (r == 1) && d[3];
            m_cmpo[i] = m_run[i] && m_cen[i] && (m_cnt[i] < m_cmp[i]);
            if (w && r == 3) m_snap[i] = m_cnt[i];
            if (start || (w && (r == 2 || r == 4))) m_pc[i] = 0;
            else if (m_run[i]) m_pc[i] = tick ? 0 : m_pc[i] + 1;
            if (expire) m_to[i] = 1; else if (w && r == 0) m_to[i] = 0;
            if (w && r == 2) m_run[i] = 0;
            else if (start) m_run[i] = 1;
            else if (stop || (expire && !m_cont[i])) m_run[i] = 0;
            if (w && r == 2) begin m_per[i] = d; m_cnt[i] = d; end
            else if (tick) m_cnt[i] = (m_cnt[i] == 0) ? m_per[i] : m_cnt[i] - 1;
            if (w && r == 1) begin m_ito[i] = d[0]; m_cont[i] = d[1]; m_cen[i] = d[4]; end
            if (w && r == 4) m_pre[i] = int'(d[7:0]);
            if (w && r == 5) m_cmp[i] = d;
        end
    endtask

    typedef struct {
        bit          w;
        int          c;
        int          r;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    initial begin
        logic [31:0] v, exp_irq, exp_cmp;
        int n;
        tbl[0]  = '{1'b0, 0, 2, 32'h0,        32'd49999};
        tbl[1]  = '{1'b0, 0, 0, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 0, 1, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 3, 5, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 3, 4, 32'hFFFFFF05, 32'h5};
        tbl[5]  = '{1'b1, 3, 5, 32'h0000ABCD, 32'hABCD};
        tbl[6]  = '{1'b1, 3, 1, 32'h1F,       32'h13};
        tbl[7]  = '{1'b0, 3, 0, 32'h0,        32'h2};
        tbl[8]  = '{1'b1, 3, 6, 32'hFFFF,     32'h0};
        tbl[9]  = '{1'b0, 3, 7, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 3, 1, 32'h08,       32'h0};
        tbl[11] = '{1'b0, 3, 0, 32'h0,        32'h0};

        reset_a = 1; reset_b = 1; cs_a = 0; cs_b = 0; write_n = 1; read_n = 1;
        address = 0; writedata = 0;
        repeat (2) @(negedge clk);
        chk("reset_readdata", rd_a, 0);
        chk("reset_irq", {31'd0, irq_a}, 0);
        chk("reset_irq_ch", {28'd0, irqch_a}, 0);
        chk("reset_cmp_out", {28'd0, cmp_a}, 0);
        reset_a = 0; reset_b = 0;

        for (int k = 0; k < 12; k++) begin
            if (tbl[k].w) wr(1'b0, tbl[k].c, tbl[k].r, tbl[k].d);
            rd(1'b0, tbl[k].c, tbl[k].r, v);
            chk($sformatf("table[%0d]", k), v, tbl[k].exp);
        end
        chk("idle_irq", {31'd0, irq_a}, 0);

        // one-shot, ch1
        wr(0, 1, 2, 9); wr(0, 1, 4, 0); wr(0, 1, 1, 32'h5);
        repeat (9) @(negedge clk);
        chk("oneshot_early", {31'd0, irqch_a[1]}, 0);
        @(negedge clk);
        chk("oneshot_irq_ch", {31'd0, irqch_a[1]}, 1);
        chk("oneshot_irq", {31'd0, irq_a}, 1);
        rd(0, 1, 0, v); chk("oneshot_status", v, 1);
        wr(0, 1, 3, 0); rd(0, 1, 3, v); chk("oneshot_hold", v, 9);
        wr(0, 1, 0, 0); chk("oneshot_clear", {31'd0, irq_a}, 0);

        // continuous with prescaler, ch2
        wr(0, 2, 2, 3); wr(0, 2, 4, 4); wr(0, 2, 1, 32'h7);
        repeat (19) @(negedge clk);
        chk("cont_early", {31'd0, irqch_a[2]}, 0);
        @(negedge clk);
        chk("cont_event1", {31'd0, irqch_a[2]}, 1);
        wr(0, 2, 0, 0);
        chk("cont_clear", {31'd0, irqch_a[2]}, 0);
        repeat (18) @(negedge clk);
        chk("cont_gap", {31'd0, irqch_a[2]}, 0);
        wr(0, 2, 0, 0);
        chk("cont_set_wins", {31'd0, irqch_a[2]}, 1);
        rd(0, 2, 0, v); chk("cont_status", v, 3);
        wr(0, 2, 1, 32'h08); wr(0, 2, 0, 0);

        // PWM, ch0
        wr(0, 0, 5, 25); wr(0, 0, 2, 99); wr(0, 0, 1, 32'h16);
        repeat (3) @(negedge clk);
        n = 0;
        repeat (200) begin @(negedge clk); n += int'(cmp_a[0]); end
        chk("pwm_duty", n, 50);
        wr(0, 0, 5, 0);
        repeat (2) @(negedge clk);
        n = 0;
        repeat (120) begin @(negedge clk); n += int'(cmp_a[0]); end
        chk("pwm_cmp0_low", n, 0);

        // control edge cases, ch0
        wr(0, 0, 2, 20); wr(0, 0, 0, 0);
        rd(0, 0, 0, v); chk("period_stops", v, 0);
        wr(0, 0, 3, 0); rd(0, 0, 3, v); chk("period_loads", v, 20);
        wr(0, 0, 1, 32'h04);
        repeat (13) @(negedge clk);
        wr(0, 0, 3, 0); rd(0, 0, 3, v); chk("snap_at_7", v, 7);
        wr(0, 0, 1, 32'h08); wr(0, 0, 1, 32'h0C);
        rd(0, 0, 0, v); chk("start_wins", v, 2);
        wr(0, 0, 1, 32'h04); wr(0, 0, 3, 0);
        rd(0, 0, 3, v); chk("start_no_reload", v, 2);
        wr(0, 0, 1, 32'h08);

        // narrow counter / partial channel map instance
        rd(1, 0, 2, v); chk("w16_default", v, 49999);
        wr(1, 0, 2, 32'h12345678); rd(1, 0, 2, v); chk("w16_period", v, 32'h5678);
        wr(1, 1, 5, 32'hFFFF1234); rd(1, 1, 5, v); chk("w16_compare", v, 32'h1234);
        wr(1, 3, 2, 32'h55); rd(1, 3, 2, v); chk("unimpl_channel", v, 0);

        // reset mid-count
        wr(0, 0, 2, 10); wr(0, 0, 5, 50); wr(0, 0, 1, 32'h16);
        wr(0, 1, 2, 2); wr(0, 1, 1, 32'h7);
        repeat (5) @(negedge clk);
        rd(0, 0, 2, v);
        chk("pre_rst_irq", {31'd0, irq_a}, 1);
        chk("pre_rst_cmp", {31'd0, cmp_a[0]}, 1);
        chk("pre_rst_rd", rd_a, 10);
        reset_a = 1; @(negedge clk); reset_a = 0;
        chk("rst_irq", {31'd0, irq_a}, 0);
        chk("rst_irq_ch", {28'd0, irqch_a}, 0);
        chk("rst_cmp", {28'd0, cmp_a}, 0);
        chk("rst_rd", rd_a, 0);
        rd(0, 1, 2, v); chk("rst_period", v, 49999);
        rd(0, 1, 0, v); chk("rst_status", v, 0);
        rd(0, 0, 1, v); chk("rst_control", v, 0);
        rd(0, 0, 5, v); chk("rst_compare", v, 0);

        // random bus traffic against the model
        reset_a = 1; @(negedge clk); reset_a = 0;
        model_reset();
        for (int k = 0; k < 1500; k++) begin
            exp_irq = 0; exp_cmp = 0;
            for (int i = 0; i < 4; i++) begin
                exp_irq[i] = m_to[i] & m_ito[i];
                exp_cmp[i] = m_cmpo[i];
            end
            chk("rand_readdata", rd_a, m_rd);
            chk("rand_irq_ch", {28'd0, irqch_a}, exp_irq);
            chk("rand_irq", {31'd0, irq_a}, {31'd0, |exp_irq[3:0]});
            chk("rand_cmp_out", {28'd0, cmp_a}, exp_cmp);
            cs_a      = ($urandom_range(0, 3) != 0);
            write_n   = ($urandom_range(0, 2) != 0);
            read_n    = !write_n;
            address   = 5'($urandom);
            writedata = $urandom_range(0, 31);
            @(posedge clk);
            model_step(cs_a, write_n, address, writedata);
            @(negedge clk);
        end
        cs_a = 0; write_n = 1; read_n = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
